// File: rtl/ika9958_pkg.sv
// ---------------------------------------------------------------------------
// ika9958_pkg
// Shared constants for the display-position tracker: horizontal FSM state
// codes, last active dot index and the active line counts for both LN modes.
// No ports.
// ---------------------------------------------------------------------------
package ika9958_pkg;

   // Horizontal FSM state codes
   typedef logic [1:0] h_state_t;
   localparam h_state_t H_IDLE  = 2'd0;
   localparam h_state_t H_DELAY = 2'd1;
   localparam h_state_t H_RUN   = 2'd2;

   // Last visible dot of an active line
   localparam logic [7:0] DOT_LAST = 8'd255;

   // Number of active lines (last line index + 1) for LN=0 and LN=1
   localparam int unsigned ACT_LINES_LO = 32'd192;
   localparam int unsigned ACT_LINES_HI = 32'd212;

   // Index of the last active line for the selected line mode
   function automatic logic [7:0] last_line(input logic ln,
                                            input int unsigned lines_lo,
                                            input int unsigned lines_hi);
      int unsigned n;
      n = ln ? lines_hi : lines_lo;
      return 8'(n - 32'd1);
   endfunction

endpackage

// File: rtl/ika9958_disp_pos_if.sv
// ---------------------------------------------------------------------------
// ika9958_disp_pos_if
// Bundles the timing ticks, register fields, read-clear pulses and the
// position/flag outputs of the display-position tracker.
//   master : drives the i_* inputs, observes the o_* outputs
//   slave  : the tracker itself (reads i_*, drives o_*)
// ---------------------------------------------------------------------------
interface ika9958_disp_pos_if;

   logic       i_cen;
   logic       i_hstart;
   logic       i_vstart;
   logic       i_ln;
   logic [7:0] i_r19;
   logic [7:0] i_r23;
   logic       i_ie1;
   logic       i_fh_clr;
   logic       i_f_clr;
   logic [4:0] i_r26;
   logic [2:0] i_r27;

   logic [7:0] o_dot_x;
   logic [7:0] o_scr_x;
   logic [7:0] o_raw_y;
   logic [7:0] o_line_y;
   logic       o_hactive;
   logic       o_vactive;
   logic       o_fh;
   logic       o_f;
   logic       o_int_n;

   modport master (
      output i_cen, i_hstart, i_vstart, i_ln, i_r19, i_r23, i_ie1,
             i_fh_clr, i_f_clr, i_r26, i_r27,
      input  o_dot_x, o_scr_x, o_raw_y, o_line_y, o_hactive, o_vactive,
             o_fh, o_f, o_int_n
   );

   modport slave (
      input  i_cen, i_hstart, i_vstart, i_ln, i_r19, i_r23, i_ie1,
             i_fh_clr, i_f_clr, i_r26, i_r27,
      output o_dot_x, o_scr_x, o_raw_y, o_line_y, o_hactive, o_vactive,
             o_fh, o_f, o_int_n
   );

endinterface

// File: rtl/ika9958_disp_flag.sv
// ---------------------------------------------------------------------------
// ika9958_disp_flag
// Status flag with set-over-clear priority, advancing only on clock enable.
//   clk_i    : clock
//   rst_n_i  : asynchronous active-low reset (flag -> 0)
//   cen_i    : clock enable
//   set_i    : set request (wins over clear)
//   clr_i    : clear request
//   flag_o   : registered flag
//   flag_d_o : next-state value, lets the owner register derived outputs
//              in step with the flag
// ---------------------------------------------------------------------------
module ika9958_disp_flag
   import ika9958_pkg::*;
(
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic cen_i,
   input  logic set_i,
   input  logic clr_i,
   output logic flag_o,
   output logic flag_d_o
);

   logic flag_q;
   logic flag_d;

   // Next flag value: set has priority over clear
   always_comb begin
      if (set_i) begin
         flag_d = 1'b1;
      end else if (clr_i) begin
         flag_d = 1'b0;
      end else begin
         flag_d = flag_q;
      end
   end

   // Flag register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         flag_q <= 1'b0;
      end else if (cen_i) begin
         flag_q <= flag_d;
      end
   end

   assign flag_o   = flag_q;
   assign flag_d_o = flag_d;

endmodule

// File: rtl/ika9958_disp_pos.sv
// ---------------------------------------------------------------------------
// ika9958_disp_pos
// Display-position tracker: pixel X counter, raw/scrolled line counters,
// active flags, line-interrupt flag FH and frame flag F.
//   phiA        : master clock
//   RST_async_n : asynchronous active-low reset
//   slv         : ika9958_disp_pos_if.slave (ticks, register fields,
//                 read-clear pulses, position and flag outputs)
// Build option: IKA9958_DISP_POS_FINE_SCROLL_EN inserts a DELAY state of
// i_r27 dot clocks between i_hstart and the first active dot.
// ---------------------------------------------------------------------------
module ika9958_disp_pos #(
   parameter int unsigned ACT_LINES_LO = ika9958_pkg::ACT_LINES_LO,
   parameter int unsigned ACT_LINES_HI = ika9958_pkg::ACT_LINES_HI
) (
   input  logic                 phiA,
   input  logic                 RST_async_n,
   ika9958_disp_pos_if.slave    slv
);
   import ika9958_pkg::*;

   h_state_t   h_state_q, h_state_d;
   logic [7:0] dot_x_q,   dot_x_d;
   logic       hactive_q, hactive_d;
   logic [7:0] raw_y_q,   raw_y_d;
   logic       vactive_q, vactive_d;
   logic       int_n_q,   int_n_d;
   logic       line_end_s;
   logic [7:0] line_y_s;
   logic [7:0] last_line_s;
   logic       fh_set_s, f_set_s;
   logic       fh_q_s, fh_d_s, f_q_s;
   logic       unused_f_d_s;

`ifdef IKA9958_DISP_POS_FINE_SCROLL_EN
   logic [2:0] delay_q, delay_d;
`else
   logic       unused_r27_s;
   assign unused_r27_s = ^slv.i_r27;
`endif

   // Horizontal FSM: a start tick always (re)starts the line, so a restart
   // inside RUN abandons the current line without a line-end event
   always_comb begin
      h_state_d  = h_state_q;
      dot_x_d    = dot_x_q;
      hactive_d  = hactive_q;
      line_end_s = 1'b0;
`ifdef IKA9958_DISP_POS_FINE_SCROLL_EN
      delay_d    = delay_q;
`endif
      if (slv.i_hstart) begin
`ifdef IKA9958_DISP_POS_FINE_SCROLL_EN
         dot_x_d = 8'd0;
         if (slv.i_r27 == 3'd0) begin
            h_state_d = H_RUN;
            hactive_d = 1'b1;
         end else begin
            h_state_d = H_DELAY;
            hactive_d = 1'b0;
            delay_d   = slv.i_r27;
         end
`else
         h_state_d = H_RUN;
         dot_x_d   = 8'd0;
         hactive_d = 1'b1;
`endif
      end else begin
         case (h_state_q)
            H_RUN: begin
               if (dot_x_q == DOT_LAST) begin
                  h_state_d  = H_IDLE;
                  dot_x_d    = 8'd0;
                  hactive_d  = 1'b0;
                  line_end_s = 1'b1;
               end else begin
                  dot_x_d = dot_x_q + 8'd1;
               end
            end
`ifdef IKA9958_DISP_POS_FINE_SCROLL_EN
            // The last delay count hands over to RUN so that a delay of N
            // shifts the first active dot by exactly N dot clocks
            H_DELAY: begin
               if (delay_q <= 3'd1) begin
                  h_state_d = H_RUN;
                  dot_x_d   = 8'd0;
                  hactive_d = 1'b1;
                  delay_d   = 3'd0;
               end else begin
                  delay_d = delay_q - 3'd1;
               end
            end
`endif
            H_IDLE: begin
               h_state_d = H_IDLE;
            end
            default: begin
               h_state_d = H_IDLE;
               dot_x_d   = 8'd0;
               hactive_d = 1'b0;
            end
         endcase
      end
   end

   assign line_y_s    = raw_y_q + slv.i_r23;
   assign last_line_s = last_line(slv.i_ln, ACT_LINES_LO, ACT_LINES_HI);
   assign fh_set_s    = line_end_s & (line_y_s == slv.i_r19);
   assign f_set_s     = line_end_s & (raw_y_q == last_line_s);

   // Vertical counter: vstart overrides the line-end increment
   always_comb begin
      raw_y_d   = raw_y_q;
      vactive_d = vactive_q;
      if (slv.i_vstart) begin
         raw_y_d   = 8'd0;
         vactive_d = 1'b1;
      end else if (line_end_s) begin
         raw_y_d = raw_y_q + 8'd1;
         if (f_set_s) begin
            vactive_d = 1'b0;
         end else begin
            vactive_d = vactive_q;
         end
      end else begin
         raw_y_d   = raw_y_q;
         vactive_d = vactive_q;
      end
   end

   assign int_n_d = ~(fh_d_s & slv.i_ie1);

   // Position, active and interrupt registers
   always_ff @(posedge phiA or negedge RST_async_n) begin
      if (!RST_async_n) begin
         h_state_q <= H_IDLE;
         dot_x_q   <= 8'd0;
         hactive_q <= 1'b0;
         raw_y_q   <= 8'd0;
         vactive_q <= 1'b0;
         int_n_q   <= 1'b1;
      end else if (slv.i_cen) begin
         h_state_q <= h_state_d;
         dot_x_q   <= dot_x_d;
         hactive_q <= hactive_d;
         raw_y_q   <= raw_y_d;
         vactive_q <= vactive_d;
         int_n_q   <= int_n_d;
      end
   end

`ifdef IKA9958_DISP_POS_FINE_SCROLL_EN
   // Fine-scroll delay counter
   always_ff @(posedge phiA or negedge RST_async_n) begin
      if (!RST_async_n) begin
         delay_q <= 3'd0;
      end else if (slv.i_cen) begin
         delay_q <= delay_d;
      end
   end
`endif

   ika9958_disp_flag u_fh (
      .clk_i    (phiA),
      .rst_n_i  (RST_async_n),
      .cen_i    (slv.i_cen),
      .set_i    (fh_set_s),
      .clr_i    (slv.i_fh_clr),
      .flag_o   (fh_q_s),
      .flag_d_o (fh_d_s)
   );

   ika9958_disp_flag u_f (
      .clk_i    (phiA),
      .rst_n_i  (RST_async_n),
      .cen_i    (slv.i_cen),
      .set_i    (f_set_s),
      .clr_i    (slv.i_f_clr),
      .flag_o   (f_q_s),
      .flag_d_o (unused_f_d_s)
   );

   assign slv.o_dot_x   = dot_x_q;
   assign slv.o_scr_x   = dot_x_q + {slv.i_r26, 3'b000};
   assign slv.o_raw_y   = raw_y_q;
   assign slv.o_line_y  = line_y_s;
   assign slv.o_hactive = hactive_q;
   assign slv.o_vactive = vactive_q;
   assign slv.o_fh      = fh_q_s;
   assign slv.o_f       = f_q_s;
   assign slv.o_int_n   = int_n_q;

endmodule

// File: tb/tb_ika9958_disp_pos.sv
// ---------------------------------------------------------------------------
// tb_ika9958_disp_pos
// Scoreboard bench for ika9958_disp_pos. The stimulus side drives inputs on
// the falling edge, runs a timeline-based reference model and queues the
// expected outputs; a monitor pops one entry per enabled rising edge and
// compares.
// ---------------------------------------------------------------------------
module tb_ika9958_disp_pos;

   logic phiA = 1'b0;
   logic RST_async_n = 1'b0;

   always #5 phiA = ~phiA;

   ika9958_disp_pos_if bus ();

   ika9958_disp_pos dut (
      .phiA        (phiA),
      .RST_async_n (RST_async_n),
      .slv         (bus.slave)
   );

   typedef struct {
      int dot_x;
      int scr_x;
      int raw_y;
      int line_y;
      int hact;
      int vact;
      int fh;
      int f;
      int int_n;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // register-field values applied at the next tick
   bit [7:0] r19_v = 8'd0, r23_v = 8'd0;
   bit [4:0] r26_v = 5'd0;
   bit [2:0] r27_v = 3'd0;
   bit       ln_v = 1'b0, ie1_v = 1'b0;
   bit       gap_en = 1'b0;

   // reference model: the line is described by the enabled-edge index at
   // which dot 0 appears; everything else is arithmetic on that timeline
   int k = 0;
   int a = 0;
   bit armed = 1'b0;
   int raw = 0;
   bit vact = 1'b0, fh = 1'b0, f = 1'b0;

   task automatic chk(input string nm, input int act, input int ex);
      checks++;
      if (act != ex) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, ex, $time);
      end
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      bit   hact;
      hact     = armed && (k >= a) && (k <= a + 255);
      e.dot_x  = hact ? (k - a) : 0;
      e.scr_x  = (e.dot_x + int'(bus.i_r26) * 8) % 256;
      e.raw_y  = raw;
      e.line_y = (raw + int'(bus.i_r23)) % 256;
      e.hact   = int'(hact);
      e.vact   = int'(vact);
      e.fh     = int'(fh);
      e.f      = int'(f);
      e.int_n  = int'(!(fh && bus.i_ie1));
      return e;
   endfunction

   task automatic model_edge();
      int d;
      bit line_end, fh_set, f_set;
      int last;
`ifdef IKA9958_DISP_POS_FINE_SCROLL_EN
      d = int'(bus.i_r27);
`else
      d = 0;
`endif
      line_end = 1'b0;
      if (bus.i_hstart) begin
         a     = k + d;
         armed = 1'b1;
      end else if (armed && k == a + 256) begin
         armed    = 1'b0;
         line_end = 1'b1;
      end
      fh_set = 1'b0;
      f_set  = 1'b0;
      if (line_end) begin
         last   = bus.i_ln ? 211 : 191;
         fh_set = (((raw + int'(bus.i_r23)) % 256) == int'(bus.i_r19));
         f_set  = (raw == last);
         raw    = (raw + 1) % 256;
         if (f_set) vact = 1'b0;
      end
      if (bus.i_vstart) begin
         raw  = 0;
         vact = 1'b1;
      end
      fh = fh_set ? 1'b1 : (bus.i_fh_clr ? 1'b0 : fh);
      f  = f_set  ? 1'b1 : (bus.i_f_clr  ? 1'b0 : f);
      exp_q.push_back(snapshot());
      k++;
   endtask

   task automatic apply_regs();
      bus.i_r19 = r19_v;
      bus.i_r23 = r23_v;
      bus.i_r26 = r26_v;
      bus.i_r27 = r27_v;
      bus.i_ln  = ln_v;
      bus.i_ie1 = ie1_v;
   endtask

   // disabled cycle with junk pulses that must be ignored
   task automatic idle_cycle();
      @(negedge phiA);
      bus.i_cen    = 1'b0;
      bus.i_hstart = 1'($urandom);
      bus.i_vstart = 1'($urandom);
      bus.i_fh_clr = 1'($urandom);
      bus.i_f_clr  = 1'($urandom);
   endtask

   task automatic tick(input bit hs, input bit vs, input bit fhc, input bit fc);
      if (gap_en) begin
         while ($urandom_range(15, 0) == 0) idle_cycle();
      end
      @(negedge phiA);
      apply_regs();
      bus.i_cen    = 1'b1;
      bus.i_hstart = hs;
      bus.i_vstart = vs;
      bus.i_fh_clr = fhc;
      bus.i_f_clr  = fc;
      model_edge();
   endtask

   task automatic do_reset();
      @(negedge phiA);
      RST_async_n  = 1'b0;
      apply_regs();
      bus.i_cen    = 1'b0;
      bus.i_hstart = 1'b0;
      bus.i_vstart = 1'b0;
      bus.i_fh_clr = 1'b0;
      bus.i_f_clr  = 1'b0;
      armed = 1'b0;
      raw   = 0;
      vact  = 1'b0;
      fh    = 1'b0;
      f     = 1'b0;
      exp_q.push_back(snapshot());
      @(negedge phiA);
      RST_async_n = 1'b1;
   endtask

   // monitor: one expected entry per enabled edge (or reset check)
   always @(posedge phiA) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("dot_x",   int'(bus.o_dot_x),   e.dot_x);
         chk("scr_x",   int'(bus.o_scr_x),   e.scr_x);
         chk("raw_y",   int'(bus.o_raw_y),   e.raw_y);
         chk("line_y",  int'(bus.o_line_y),  e.line_y);
         chk("hactive", int'(bus.o_hactive), e.hact);
         chk("vactive", int'(bus.o_vactive), e.vact);
         chk("fh",      int'(bus.o_fh),      e.fh);
         chk("f",       int'(bus.o_f),       e.f);
         chk("int_n",   int'(bus.o_int_n),   e.int_n);
      end
   end

   initial begin
      bus.i_cen    = 1'b0;
      bus.i_hstart = 1'b0;
      bus.i_vstart = 1'b0;
      bus.i_fh_clr = 1'b0;
      bus.i_f_clr  = 1'b0;
      apply_regs();

      // power-on reset, then a line aborted by reset at dot 100
      do_reset();
      repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (100) tick(1'b0, 1'b0, 1'b0, 1'b0);
      do_reset();
      repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);

      // full line with coarse scroll 3 (24 dots): covers the 232 -> 0 wrap
      r26_v = 5'd3;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (258) tick(1'b0, 1'b0, 1'b0, 1'b0);
      r26_v = 5'd0;

      // a whole frame: FH at raw line 10, F at 191 (LN=0) then 211 (LN=1)
      gap_en = 1'b1;
      r23_v  = 8'd250;
      r19_v  = 8'd4;
      ie1_v  = 1'b1;
      ln_v   = 1'b0;
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      for (int ln_idx = 0; ln_idx <= 212; ln_idx++) begin
         r26_v = 5'($urandom);
         if (ln_idx == 20)  r19_v = 8'd14;
         if (ln_idx == 21)  r19_v = 8'd4;
         if (ln_idx == 192) ln_v = 1'b1;
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         for (int i = 1; i <= 255; i++) begin
            if (ln_idx == 30 && i == 128) r23_v = 8'd7;
            if (ln_idx == 30 && i == 200) r23_v = 8'd250;
            tick(1'b0, 1'b0,
                 (i == 100) && (ln_idx == 15 || ln_idx == 25),
                 (i == 50) && (ln_idx == 195));
         end
         // line end: clear coincides with a matching set on line 20,
         // vstart coincides with the end of line 212
         tick(1'b0, ln_idx == 212, ln_idx == 20, 1'b0);
      end

      // fine-scroll delay and a reload during the delay
      gap_en = 1'b0;
      r27_v  = 3'd5;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (270) tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (270) tick(1'b0, 1'b0, 1'b0, 1'b0);
      r27_v = 3'd0;

      // randomized traffic, including restarts and a reset
      gap_en = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(63, 0) == 0) r19_v = 8'($urandom);
         if ($urandom_range(63, 0) == 0) r23_v = 8'($urandom);
         if ($urandom_range(15, 0) == 0) r26_v = 5'($urandom);
         if ($urandom_range(63, 0) == 0) r27_v = 3'($urandom);
         if ($urandom_range(63, 0) == 0) ln_v  = 1'($urandom);
         if ($urandom_range(63, 0) == 0) ie1_v = 1'($urandom);
         if (n == 2000) do_reset();
         tick($urandom_range(199, 0) == 0, $urandom_range(499, 0) == 0,
              $urandom_range(39, 0) == 0, $urandom_range(39, 0) == 0);
      end

      gap_en = 1'b0;
      repeat (3) idle_cycle();
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
